// File: rtl/seg_scan_decoder.sv
// Seven-segment bus observer: synchronises a multiplexed 4-digit active-low display bus
// and recovers each digit's hex value, glyph legality and frame completion.
`timescale 1ns/1ps
module seg_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        Clk,
  input  logic        ResetN,
  input  logic [6:0]  Segments,
  input  logic [3:0]  Anodes,
  output logic [15:0] Digits,
  output logic [3:0]  DigitValid,
  output logic [3:0]  DigitError,
  output logic        FrameValid,
  output logic        Stale
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  // Returns {legal, nibble}; legal=0 for blank and unrecognised patterns.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    case (seg)
      7'b1000000: decode_glyph = 5'h10;
      7'b1111001: decode_glyph = 5'h11;
      7'b0100100: decode_glyph = 5'h12;
      7'b0110000: decode_glyph = 5'h13;
      7'b0011001: decode_glyph = 5'h14;
      7'b0010010: decode_glyph = 5'h15;
      7'b0000010: decode_glyph = 5'h16;
      7'b1111000: decode_glyph = 5'h17;
      7'b0000000: decode_glyph = 5'h18;
      7'b0010000: decode_glyph = 5'h19;
      7'b0001000: decode_glyph = 5'h1A;
      7'b0000011: decode_glyph = 5'h1B;
      7'b1000110: decode_glyph = 5'h1C;
      7'b0100001: decode_glyph = 5'h1D;
      7'b0000110: decode_glyph = 5'h1E;
      7'b0001110: decode_glyph = 5'h1F;
      default:    decode_glyph = 5'h00;
    endcase
  endfunction

  logic [10:0]   sync1_q, sync2_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] to_q, to_d;
  logic [3:0]    seen_q, seen_d, valid_q, valid_d, err_q, err_d;
  logic [15:0]   dig_q, dig_d;
  logic          frame_q, frame_d;
  logic          cap, qual;
  logic [3:0]    an_low, seen_or;
  logic [4:0]    glyph;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
      cnt_q   <= '0;
      to_q    <= '0;
      seen_q  <= '0;
      valid_q <= '0;
      err_q   <= '0;
      dig_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      sync1_q <= {Anodes, Segments};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      seen_q  <= seen_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      dig_q   <= dig_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    cnt_d   = (sync2_q != prev_q) ? '0 : (cnt_q == CMAX) ? CMAX : cnt_q + CW'(1);
    // Fire only on the cycle the counter first reaches its limit: one capture per dwell.
    cap     = (cnt_d == CMAX) && (cnt_q != CMAX);
    an_low  = ~sync2_q[10:7];
    qual    = cap && (an_low != 4'd0) && ((an_low & (an_low - 4'd1)) == 4'd0);
    glyph   = decode_glyph(sync2_q[6:0]);
    seen_or = seen_q | an_low;
    dig_d   = dig_q;
    valid_d = valid_q;
    err_d   = err_q;
    seen_d  = seen_q;
    frame_d = 1'b0;
    to_d    = (to_q == TMAX) ? TMAX : to_q + TW'(1);
    if (qual) begin
      for (int n = 0; n < 4; n++) begin
        if (an_low[n]) begin
          if (glyph[4]) begin
            dig_d[4*n +: 4] = glyph[3:0];
            valid_d[n]      = 1'b1;
            err_d[n]        = 1'b0;
          end else if (sync2_q[6:0] == 7'h7F) begin
            dig_d[4*n +: 4] = 4'h0;
            valid_d[n]      = 1'b0;
            err_d[n]        = 1'b0;
          end else begin
            valid_d[n]      = 1'b0;
            err_d[n]        = 1'b1;
          end
        end
      end
      to_d = '0;
      if (seen_or == 4'hF) begin
        frame_d = 1'b1;
        seen_d  = 4'h0;
      end else begin
        seen_d  = seen_or;
      end
    end
  end

  assign Digits     = dig_q;
  assign DigitValid = valid_q;
  assign DigitError = err_q;
  assign FrameValid = frame_q;
  assign Stale      = (to_q == TMAX);

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the team's binary-to-seven-segment display drivers: observes a multiplexed 4-digit, active-low seven-segment bus (segment lines plus digit anodes) and recovers the hex value shown on each digit.
- Used on the bench and in loopback designs to check display-driver output without a camera or eye.
- Synchronises the asynchronous bus and waits until each pattern has been stable for a set time.
- Decodes the pattern to a nibble, flags illegal glyphs, and reports a completed frame once all four digits have been seen.

Parameters:
- STABLE_CYCLES, 4, consecutive identical synchronised samples required before a pattern is captured (must be at least 2).
- TIMEOUT_CYCLES, 65535, number of clocks with no capture after which Stale asserts (must be at least 1).

Ports:
- Clk  input  1  system clock, rising edge.
- ResetN  input  1  asynchronous, active-low reset.
- Segments  input  7  active-low segment lines. Bit0=a … bit6=g (pattern 7'b1000000 shows "0").
- Anodes  input  4  active-low digit selects. Bit n low selects digit n.
- Digits  output  16  recovered nibbles. Digit n is on [4n+3:4n].
- DigitValid  output  4  bit n=1: digit n last showed a legal hex glyph.
- DigitError  output  4  bit n=1: digit n last showed an unrecognised, non-blank pattern.
- FrameValid  output  1  one-cycle pulse when all four digits have been captured since the previous pulse.
- Stale  output  1  no capture for TIMEOUT_CYCLES clocks.

Behaviour:
- Reset (async assert, sync release):
  - Digits=0, DigitValid=0, DigitError=0, FrameValid=0, Stale=0.
  - Synchroniser flops are set to all-ones (idle bus).
  - Seen mask, stability counter and timeout counter are cleared.
- Synchronisation: {Anodes,Segments} passes through a 2-flop synchroniser. All other logic sees only the second stage.
- Stability counter:
  - Clears when the synchronised 11-bit word differs from its value on the previous cycle.
  - Otherwise increments, saturating at STABLE_CYCLES.
  - A capture event occurs on the single cycle the counter reaches STABLE_CYCLES, so one dwell produces exactly one capture however long it is held.
  - Latency from an input change to the capture cycle is 2+STABLE_CYCLES clocks. Outputs update on the following edge.
- Anode qualification:
  - A capture event is acted on only if exactly one Anodes bit is low.
  - All-high or multiple-low anode words are discarded. They cause no state change and do not reset the timeout counter.
- Glyph table (Segments value -> nibble):
  - 0: 1000000, 1: 1111001, 2: 0100100, 3: 0110000
  - 4: 0011001, 5: 0010010, 6: 0000010, 7: 1111000
  - 8: 0000000, 9: 0010000, A: 0001000, b: 0000011
  - C: 1000110, d: 0100001, E: 0000110, F: 0001110
- Capture on a qualified digit n, by pattern:
  - Table match: Digits[n]=nibble, DigitValid[n]=1, DigitError[n]=0.
  - Blank (1111111): Digits[n]=0, DigitValid[n]=0, DigitError[n]=0.
  - Any other pattern: Digits[n] holds its old value, DigitValid[n]=0, DigitError[n]=1.
  - In all three cases, set seen[n] and clear the timeout counter.
- Frame:
  - When a capture makes seen==4'b1111, FrameValid pulses on the same edge that updates Digits, and seen clears to 0.
  - Re-capturing an already-seen digit before the frame completes overwrites that digit and does not pulse FrameValid.
- Stale:
  - The timeout counter increments every cycle with no qualified capture, saturating at TIMEOUT_CYCLES.
  - Stale=1 while the counter equals TIMEOUT_CYCLES.
  - A qualified capture clears the counter and Stale on the same edge.
- Reset mid-dwell or mid-frame: all partial state is lost. Capturing restarts from an empty seen mask.

Test Plan:
- Hold Anodes=1110, Segments=1111001 for 10 clocks after reset -> one capture at clock 6: Digits[3:0]=1, DigitValid=0001, FrameValid stays 0.
- Scan digits 0..3 showing 0x3, 0xA, 0xd, 0xF, holding each 8 clocks -> single FrameValid pulse, Digits=16'hFDA3, DigitValid=1111, DigitError=0000.
- Glitch: Segments toggles 0000000 -> 0000010 after 3 stable clocks (STABLE_CYCLES=4) -> no capture of 0000000. The 6 is captured 4 clocks after the synchronised change.
- Illegal glyph 1010101 on digit 2 after a valid 0x5 -> Digits[11:8]=5 retained, DigitValid[2]=0, DigitError[2]=1. Blank on digit 2 afterwards clears both flags.
- Anodes=1100 and Anodes=1111 held 20 clocks each -> no captures, seen mask unchanged. With TIMEOUT_CYCLES=30, Stale asserts on the 30th capture-free clock and clears on the next valid capture.
- Assert ResetN low mid-frame after digits 0 and 1 are captured -> all outputs 0 immediately. After release, digits 2 and 3 alone produce no FrameValid.
